// File: rtl/milano_pkg.sv
// Shared types for the data bus arbiter: the owner id recorded per granted
// transaction and a helper used by the round-robin selector.
package milano_pkg;

    typedef enum logic {
        ARB_OWNER_LSU = 1'b0,
        ARB_OWNER_IF  = 1'b1
    } arb_owner_e;

    localparam logic [3:0] ARB_IF_BE = 4'hF;

    function automatic arb_owner_e arb_other_owner(arb_owner_e owner);
        return (owner == ARB_OWNER_LSU) ? ARB_OWNER_IF : ARB_OWNER_LSU;
    endfunction

endpackage

// File: rtl/arb_owner_fifo.sv
// In-order record of which port owns each granted-but-unanswered transaction.
// The head entry says where the next memory response must be delivered.
module arb_owner_fifo
    import milano_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push,
    input  logic                   push_owner,
    input  logic                   pop,
    output logic                   head_owner,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    arb_owner_e       entries [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] next_ptr(logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign push_ok    = push & ~full;
    assign pop_ok     = pop & ~empty;
    assign head_owner = entries[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= ARB_OWNER_LSU;
            end
        end else begin
            if (push_ok) begin
                entries[wr_ptr] <= arb_owner_e'(push_owner);
                wr_ptr          <= next_ptr(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            // A simultaneous push and pop leaves the occupancy unchanged.
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/data_bus_arbiter.sv
// Shares one req/gnt/rvalid memory port between the LSU (port 0) and instruction
// fetch (port 1), holding a stalled owner stable and routing in-order responses.
module data_bus_arbiter
    import milano_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter bit LSU_PRIORITY    = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        lsu_req_i,
    output logic        lsu_gnt_o,
    output logic        lsu_rvalid_o,
    input  logic [31:0] lsu_addr_i,
    input  logic        lsu_we_i,
    input  logic [3:0]  lsu_be_i,
    input  logic [31:0] lsu_wdata_i,
    output logic [31:0] lsu_rdata_o,
    input  logic        if_req_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    output logic        busy_o,
    output logic        proto_err_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    logic             lock_q;
    arb_owner_e       lock_owner_q;
    arb_owner_e       rr_last_q;
    arb_owner_e       sel_owner;
    arb_owner_e       head_owner;
    logic             fifo_head;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic             req_any;
    logic             accept;
    logic             pop;

    // Requests are masked while reset is low so every output reads 0 in reset.
    assign req_any   = (lsu_req_i | if_req_i) & rst_ni;
    assign mem_req_o = req_any & ~full;
    assign accept    = mem_req_o & mem_gnt_i;
    assign pop       = mem_rvalid_i & ~empty;
    assign busy_o    = (count != '0) | mem_req_o;
    assign head_owner = arb_owner_e'(fifo_head);

    always_comb begin
        sel_owner = ARB_OWNER_LSU;
        if (lock_q) begin
            sel_owner = lock_owner_q;
        end else if (LSU_PRIORITY || !(lsu_req_i && if_req_i)) begin
            sel_owner = lsu_req_i ? ARB_OWNER_LSU : ARB_OWNER_IF;
        end else begin
            sel_owner = arb_other_owner(rr_last_q);
        end
    end

    always_comb begin
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        lsu_gnt_o   = 1'b0;
        if_gnt_o    = 1'b0;
        if (req_any) begin
            if (sel_owner == ARB_OWNER_LSU) begin
                mem_addr_o  = lsu_addr_i;
                mem_we_o    = lsu_we_i;
                mem_be_o    = lsu_be_i;
                mem_wdata_o = lsu_wdata_i;
                lsu_gnt_o   = accept;
            end else begin
                mem_addr_o  = if_addr_i;
                mem_be_o    = ARB_IF_BE;
                if_gnt_o    = accept;
            end
        end
    end

    always_comb begin
        lsu_rvalid_o = pop & (head_owner == ARB_OWNER_LSU);
        if_rvalid_o  = pop & (head_owner == ARB_OWNER_IF);
        lsu_rdata_o  = lsu_rvalid_o ? mem_rdata_i : '0;
        if_rdata_o   = if_rvalid_o ? mem_rdata_i : '0;
    end

    // The lock freezes the owner while the slave withholds gnt; when full no
    // request is presented, so an existing lock simply carries over.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q       <= 1'b0;
            lock_owner_q <= ARB_OWNER_LSU;
            rr_last_q    <= ARB_OWNER_LSU;
            proto_err_o  <= 1'b0;
        end else begin
            if (accept) begin
                lock_q    <= 1'b0;
                rr_last_q <= sel_owner;
            end else if (mem_req_o) begin
                lock_q       <= 1'b1;
                lock_owner_q <= sel_owner;
            end
            if (mem_rvalid_i && empty) begin
                proto_err_o <= 1'b1;
            end
        end
    end

    arb_owner_fifo #(
        .DEPTH(MAX_OUTSTANDING)
    ) u_owner_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push       (accept),
        .push_owner (sel_owner),
        .pop        (pop),
        .head_owner (fifo_head),
        .full       (full),
        .empty      (empty),
        .count      (count)
    );

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter: a fixed-priority and a round-robin
// instance share the same stimulus and are compared against hand-derived values.
module tb_data_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic        lsu_req;
    logic [31:0] lsu_addr;
    logic        lsu_we;
    logic [3:0]  lsu_be;
    logic [31:0] lsu_wdata;
    logic        if_req;
    logic [31:0] if_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic        lsu_gnt, lsu_rvalid, if_gnt, if_rvalid;
    logic [31:0] lsu_rdata, if_rdata, mem_addr, mem_wdata;
    logic        mem_req, mem_we, busy, proto_err;
    logic [3:0]  mem_be;

    logic        rr_lsu_gnt, rr_lsu_rvalid, rr_if_gnt, rr_if_rvalid;
    logic [31:0] rr_lsu_rdata, rr_if_rdata, rr_mem_addr, rr_mem_wdata;
    logic        rr_mem_req, rr_mem_we, rr_busy, rr_proto_err;
    logic [3:0]  rr_mem_be;

    int check_count = 0;
    int pass_count  = 0;
    int fail_count  = 0;

    data_bus_arbiter #(.MAX_OUTSTANDING(2), .LSU_PRIORITY(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .lsu_req_i(lsu_req), .lsu_gnt_o(lsu_gnt), .lsu_rvalid_o(lsu_rvalid),
        .lsu_addr_i(lsu_addr), .lsu_we_i(lsu_we), .lsu_be_i(lsu_be),
        .lsu_wdata_i(lsu_wdata), .lsu_rdata_o(lsu_rdata),
        .if_req_i(if_req), .if_gnt_o(if_gnt), .if_rvalid_o(if_rvalid),
        .if_addr_i(if_addr), .if_rdata_o(if_rdata),
        .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
        .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_be_o(mem_be),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
        .busy_o(busy), .proto_err_o(proto_err)
    );

    data_bus_arbiter #(.MAX_OUTSTANDING(2), .LSU_PRIORITY(1'b0)) dut_rr (
        .clk_i(clk), .rst_ni(rst_n),
        .lsu_req_i(lsu_req), .lsu_gnt_o(rr_lsu_gnt), .lsu_rvalid_o(rr_lsu_rvalid),
        .lsu_addr_i(lsu_addr), .lsu_we_i(lsu_we), .lsu_be_i(lsu_be),
        .lsu_wdata_i(lsu_wdata), .lsu_rdata_o(rr_lsu_rdata),
        .if_req_i(if_req), .if_gnt_o(rr_if_gnt), .if_rvalid_o(rr_if_rvalid),
        .if_addr_i(if_addr), .if_rdata_o(rr_if_rdata),
        .mem_req_o(rr_mem_req), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
        .mem_addr_o(rr_mem_addr), .mem_we_o(rr_mem_we), .mem_be_o(rr_mem_be),
        .mem_wdata_o(rr_mem_wdata), .mem_rdata_i(mem_rdata),
        .busy_o(rr_busy), .proto_err_o(rr_proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic l_req, input logic [31:0] l_addr,
                                  input logic l_we, input logic [3:0] l_be,
                                  input logic [31:0] l_wdata, input logic i_req,
                                  input logic [31:0] i_addr, input logic gnt,
                                  input logic rvalid, input logic [31:0] rdata);
        lsu_req    = l_req;
        lsu_addr   = l_addr;
        lsu_we     = l_we;
        lsu_be     = l_be;
        lsu_wdata  = l_wdata;
        if_req     = i_req;
        if_addr    = i_addr;
        mem_gnt    = gnt;
        mem_rvalid = rvalid;
        mem_rdata  = rdata;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_output("reset_mem_req", 32'(mem_req), 0);
        check_output("reset_busy", 32'(busy), 0);
        check_output("reset_proto_err", 32'(proto_err), 0);
        check_output("reset_lsu_rvalid", 32'(lsu_rvalid), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        $display("[TB] LSU read with two-cycle response");
        apply_stimulus(1, 32'h100, 0, 4'hF, 0, 0, 0, 1, 0, 0);
        check_output("lsu_rd_mem_req", 32'(mem_req), 1);
        check_output("lsu_rd_addr", mem_addr, 32'h100);
        check_output("lsu_rd_gnt", 32'(lsu_gnt), 1);
        check_output("lsu_rd_if_gnt", 32'(if_gnt), 0);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_output("lsu_rd_busy_wait", 32'(busy), 1);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF);
        check_output("lsu_rd_rvalid", 32'(lsu_rvalid), 1);
        check_output("lsu_rd_rdata", lsu_rdata, 32'hDEADBEEF);
        check_output("lsu_rd_if_rvalid", 32'(if_rvalid), 0);
        check_output("lsu_rd_if_rdata", if_rdata, 0);
        check_output("rr_lsu_rd_rvalid", 32'(rr_lsu_rvalid), 1);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_output("lsu_rd_busy_idle", 32'(busy), 0);
        tick();

        $display("[TB] LSU write then IF read payloads");
        apply_stimulus(1, 32'h300, 1, 4'b0011, 32'h1234, 0, 0, 1, 0, 0);
        check_output("lsu_wr_we", 32'(mem_we), 1);
        check_output("lsu_wr_be", 32'(mem_be), 32'h3);
        check_output("lsu_wr_wdata", mem_wdata, 32'h1234);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0);
        check_output("lsu_wr_rvalid", 32'(lsu_rvalid), 1);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 1, 32'h200, 1, 0, 0);
        check_output("if_rd_be", 32'(mem_be), 32'hF);
        check_output("if_rd_we", 32'(mem_we), 0);
        check_output("if_rd_addr", mem_addr, 32'h200);
        check_output("if_rd_wdata", mem_wdata, 0);
        check_output("if_rd_gnt", 32'(if_gnt), 1);
        check_output("if_rd_lsu_gnt", 32'(lsu_gnt), 0);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h13);
        check_output("if_rd_rvalid", 32'(if_rvalid), 1);
        check_output("if_rd_rdata", if_rdata, 32'h13);
        check_output("if_rd_lsu_rvalid", 32'(lsu_rvalid), 0);
        check_output("if_rd_lsu_rdata", lsu_rdata, 0);
        tick();

        // Round-robin instance last granted IF, so the contest starts with LSU.
        $display("[TB] contest: fixed priority vs round robin");
        apply_stimulus(1, 32'h400, 0, 4'hF, 0, 1, 32'h500, 1, 0, 0);
        check_output("c1_lsu_gnt", 32'(lsu_gnt), 1);
        check_output("c1_addr", mem_addr, 32'h400);
        check_output("c1_rr_lsu_gnt", 32'(rr_lsu_gnt), 1);
        check_output("c1_rr_if_gnt", 32'(rr_if_gnt), 0);
        tick();
        apply_stimulus(1, 32'h400, 0, 4'hF, 0, 1, 32'h500, 1, 1, 32'hA1);
        check_output("c2_lsu_gnt", 32'(lsu_gnt), 1);
        check_output("c2_rr_if_gnt", 32'(rr_if_gnt), 1);
        check_output("c2_rr_addr", rr_mem_addr, 32'h500);
        check_output("c2_rr_lsu_rvalid", 32'(rr_lsu_rvalid), 1);
        check_output("c2_lsu_rvalid", 32'(lsu_rvalid), 1);
        tick();
        apply_stimulus(1, 32'h400, 0, 4'hF, 0, 1, 32'h500, 1, 1, 32'hA2);
        check_output("c3_lsu_gnt", 32'(lsu_gnt), 1);
        check_output("c3_rr_lsu_gnt", 32'(rr_lsu_gnt), 1);
        check_output("c3_rr_if_rvalid", 32'(rr_if_rvalid), 1);
        check_output("c3_rr_if_rdata", rr_if_rdata, 32'hA2);
        check_output("c3_rr_lsu_rdata", rr_lsu_rdata, 0);
        check_output("c3_lsu_rdata", lsu_rdata, 32'hA2);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 1, 32'h500, 1, 1, 32'hA3);
        check_output("c4_if_gnt", 32'(if_gnt), 1);
        check_output("c4_addr", mem_addr, 32'h500);
        check_output("c4_lsu_rvalid", 32'(lsu_rvalid), 1);
        check_output("c4_rr_lsu_rvalid", 32'(rr_lsu_rvalid), 1);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA4);
        check_output("c5_if_rvalid", 32'(if_rvalid), 1);
        check_output("c5_if_rdata", if_rdata, 32'hA4);
        check_output("c5_rr_if_rvalid", 32'(rr_if_rvalid), 1);
        tick();

        $display("[TB] IF stalled by slave while LSU raises request");
        apply_stimulus(0, 0, 0, 0, 0, 1, 32'h600, 0, 0, 0);
        check_output("s0_addr", mem_addr, 32'h600);
        check_output("s0_if_gnt", 32'(if_gnt), 0);
        tick();
        for (int i = 1; i < 3; i++) begin
            apply_stimulus(1, 32'h700, 0, 4'hF, 0, 1, 32'h600, 0, 0, 0);
            check_output("s_locked_addr", mem_addr, 32'h600);
            check_output("s_locked_lsu_gnt", 32'(lsu_gnt), 0);
            tick();
        end
        apply_stimulus(1, 32'h700, 0, 4'hF, 0, 1, 32'h600, 1, 0, 0);
        check_output("s3_if_gnt", 32'(if_gnt), 1);
        check_output("s3_lsu_gnt", 32'(lsu_gnt), 0);
        check_output("s3_addr", mem_addr, 32'h600);
        tick();
        apply_stimulus(1, 32'h700, 0, 4'hF, 0, 0, 0, 1, 0, 0);
        check_output("s4_lsu_gnt", 32'(lsu_gnt), 1);
        check_output("s4_addr", mem_addr, 32'h700);
        tick();

        $display("[TB] full with two outstanding");
        apply_stimulus(1, 32'h800, 0, 4'hF, 0, 0, 0, 1, 0, 0);
        check_output("f1_mem_req", 32'(mem_req), 0);
        check_output("f1_lsu_gnt", 32'(lsu_gnt), 0);
        check_output("f1_busy", 32'(busy), 1);
        tick();
        apply_stimulus(1, 32'h800, 0, 4'hF, 0, 0, 0, 1, 1, 32'hB1);
        check_output("f2_mem_req", 32'(mem_req), 0);
        check_output("f2_lsu_gnt", 32'(lsu_gnt), 0);
        check_output("f2_if_rvalid", 32'(if_rvalid), 1);
        check_output("f2_if_rdata", if_rdata, 32'hB1);
        tick();
        apply_stimulus(1, 32'h800, 0, 4'hF, 0, 0, 0, 1, 0, 0);
        check_output("f3_mem_req", 32'(mem_req), 1);
        check_output("f3_lsu_gnt", 32'(lsu_gnt), 1);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hB2);
        check_output("f4_lsu_rvalid", 32'(lsu_rvalid), 1);
        check_output("f4_lsu_rdata", lsu_rdata, 32'hB2);
        check_output("f4_if_rvalid", 32'(if_rvalid), 0);
        tick();

        $display("[TB] reset mid-flight and stray response");
        apply_stimulus(1, 32'h900, 0, 4'hF, 0, 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b0;
        #1;
        check_output("rst_mem_req", 32'(mem_req), 0);
        check_output("rst_busy", 32'(busy), 0);
        check_output("rst_lsu_gnt", 32'(lsu_gnt), 0);
        check_output("rst_mem_addr", mem_addr, 0);
        apply_stimulus(0, 32'h900, 0, 4'hF, 0, 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        tick();
        apply_stimulus(0, 32'h900, 0, 4'hF, 0, 1, 32'hA00, 0, 0, 0);
        check_output("post_rst_unlocked_addr", mem_addr, 32'hA00);
        tick();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hC1);
        check_output("stray_lsu_rvalid", 32'(lsu_rvalid), 0);
        check_output("stray_if_rvalid", 32'(if_rvalid), 0);
        check_output("stray_lsu_rdata", lsu_rdata, 0);
        check_output("stray_err_before_edge", 32'(proto_err), 0);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_output("stray_err_set", 32'(proto_err), 1);
        tick();
        check_output("stray_err_sticky", 32'(proto_err), 1);
        check_output("stray_rr_err_sticky", 32'(rr_proto_err), 1);
        check_output("stray_busy", 32'(busy), 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
